// File: rtl/bf16_mul_rr_sched.sv
// Round-robin sharing of one pipelined bf16 multiplier among N_REQ requesters; a tag pipe remembers the owner of each in-flight op.
// Grant is combinational, response arrives MUL_LATENCY+2 cycles after transfer; no backpressure on the multiplier or the responses.
module bf16_mul_rr_sched #(
    parameter int N_REQ       = 4,
    parameter int MUL_LATENCY = 3,
    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int IW = $clog2(MUL_LATENCY + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [31:0]           mul_operands,
    output logic                  mul_stb,
    input  logic [15:0]           mul_z,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [15:0]           rsp_z,
    output logic [IW-1:0]         inflight,
    output logic                  idle
);

    logic [LW-1:0]    last;
    logic [LW-1:0]    grant_idx;
    logic [LW-1:0]    cand;
    logic             found;
    logic [N_REQ-1:0] grant;
    logic             xfer;
    logic [15:0]      sel_a;
    logic [15:0]      sel_b;
    logic [N_REQ-1:0] rsp_onehot;

    logic             tag_vld [0:MUL_LATENCY];
    logic [LW-1:0]    tag_idx [0:MUL_LATENCY];

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = LW'((int'(last) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found && en && !rst) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i == int'(grant_idx)) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
        end
    end

    // Last tag stage lines up with the cycle in which mul_z carries its product.
    always_comb begin
        rsp_onehot = '0;
        if (tag_vld[MUL_LATENCY]) begin
            rsp_onehot[tag_idx[MUL_LATENCY]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last         <= LW'(N_REQ - 1);
            mul_stb      <= 1'b0;
            mul_operands <= '0;
            rsp_valid    <= '0;
            rsp_z        <= '0;
            inflight     <= '0;
            for (int s = 0; s <= MUL_LATENCY; s++) begin
                tag_vld[s] <= 1'b0;
                tag_idx[s] <= '0;
            end
        end else begin
            mul_stb <= xfer;
            if (xfer) begin
                last         <= grant_idx;
                mul_operands <= {sel_a, sel_b};
            end
            tag_vld[0] <= xfer;
            tag_idx[0] <= grant_idx;
            for (int s = 1; s <= MUL_LATENCY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
            rsp_valid <= rsp_onehot;
            if (tag_vld[MUL_LATENCY]) begin
                rsp_z <= mul_z;
            end
            inflight <= inflight + IW'(xfer) - IW'(tag_vld[MUL_LATENCY]);
        end
    end

    assign idle = (inflight == '0);

endmodule

// File: doc/bf16_mul_rr_sched.md
# bf16_mul_rr_sched

Round-robin scheduler that shares one fixed-latency pipelined bf16 multiplier among N_REQ requesters. Each cycle it grants at most one pending operand pair, packs it into the multiplier's 32-bit operand word, and tracks the owner of every in-flight operation in a tag shift register. When the product emerges, it is steered back to the owning requester with a one-hot response strobe. It sits between the probabilistic-circuit node evaluators and the single shared bf16 multiplier instance.

## Interface
- N_REQ, 4: number of requesters (2..8).
- MUL_LATENCY, 3: cycles from the multiplier's operand strobe to a valid `mul_z`.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  when low, no new grants; in-flight operations still drain.
- req_valid  in  N_REQ  requester i has an operand pair pending.
- req_a  in  16*N_REQ  bf16 operand A of requester i at bits [16i+15:16i].
- req_b  in  16*N_REQ  bf16 operand B, same packing.
- req_ready  out  N_REQ  one-hot grant, combinational; a transfer occurs when req_valid[i] & req_ready[i].
- mul_operands  out  32  registered; {A,B}, with A in [31:16] and B in [15:0].
- mul_stb  out  1  registered; operand strobe to the multiplier.
- mul_z  in  16  multiplier product, valid exactly MUL_LATENCY cycles after the `mul_stb` cycle.
- rsp_valid  out  N_REQ  registered one-hot; the product for requester i is on rsp_z.
- rsp_z  out  16  registered product.
- inflight  out  clog2(MUL_LATENCY+2)  number of accepted operations whose response has not yet been issued.
- idle  out  1  high when inflight == 0.

## Operation
- Arbitration:
  - The pointer `last` (log2 N_REQ bits) holds the index of the most recent grant.
  - The grant goes to the first i with req_valid[i] set, searching from last+1 upward with wrap at N_REQ-1 → 0.
  - `req_ready` is all-zero when en=0, when rst=1, or when no request is pending.
  - `last` updates only on a transfer.
- Issue:
  - On a transfer edge, the block registers mul_operands={req_a[i],req_b[i]} and mul_stb=1, and pushes tag {1,i} into stage 0 of the tag pipe.
  - Otherwise mul_stb=0, mul_operands holds its last value, and the tag valid bit is 0.
- Tag pipe:
  - MUL_LATENCY+1 stages of {valid, index}, shifted every cycle with no stall, since the multiplier cannot be backpressured.
  - The stage aligned with the `mul_z` cycle drives the response register.
- Response:
  - When the aligned tag is valid, the next edge sets rsp_valid=onehot(index) and rsp_z=mul_z.
  - Otherwise rsp_valid=0 and rsp_z holds its value.
  - Requesters must accept a response in the cycle it is presented; no response backpressure exists.
- inflight counting:
  - Increments on a transfer and decrements on a response issue.
  - A simultaneous transfer and response leaves it unchanged.
  - Maximum value is MUL_LATENCY+1, so it never saturates under legal use.
- Throughput: one operation per cycle in total. A requester holding req_valid continuously while others are also pending receives one grant every N_REQ cycles.
- The block performs no arithmetic on operands; bf16 special cases are the multiplier's concern.

## Timing
- Reset values: req_ready=0, mul_stb=0, mul_operands=0, rsp_valid=0, rsp_z=0, inflight=0, idle=1, last=N_REQ-1 (first grant goes to requester 0), all tag valid bits 0.
- Latency:
  - Transfer in cycle t → mul_stb=1 in cycle t+1.
  - `mul_z` is sampled in cycle t+1+MUL_LATENCY.
  - rsp_valid=1 in cycle t+2+MUL_LATENCY, which is 5 cycles for the default.
- Ordering: responses return in exactly issue order with no reordering. Back-to-back transfers produce back-to-back responses.
- Reset mid-operation:
  - All in-flight tags are dropped; no response is ever issued for them.
  - Stale `mul_z` values arriving after reset are ignored.
- en falling while operations are in flight: no new grants, and the pending responses still arrive on schedule.
- A requester may change its operands or deassert req_valid in any cycle in which it is not granted.

## Test plan
- Single request, requester 2 with A=0x3FC0 (1.5) and B=0x4000 (2.0) → in cycle t+1: req_ready=0b0100 at t, mul_operands=0x3FC04000, mul_stb=1. In cycle t+5: rsp_valid=0b0100, rsp_z=0x4040. inflight is 1 during t+1..t+4 and 0 at t+5.
- All four requesters hold req_valid for 8 cycles after reset → grant order 0,1,2,3,0,1,2,3 with one mul_stb per cycle. Each response appears 5 cycles after its grant, one-hot to the matching requester.
- Requesters 1 and 3 pending with last=1 → grant 3, then 1. With last=3 and only requester 3 pending → grant 3 again after wrap.
- en=0 while requester 0 is pending and 2 operations are in flight → req_ready stays 0, both responses are still issued, idle rises after the last one. Raising en grants requester 0 in the same cycle.
- rst asserted for 1 cycle with 3 operations in flight → no rsp_valid in the following 6 cycles, inflight=0, idle=1. The next request is granted to requester 0.
- Transfer and response in the same cycle with inflight=4 → inflight remains 4.
